// File: rtl/mul_add_reconstruct.sv
// Sequential shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// Rebuilds a restoring-divider dividend from quotient, divisor and remainder over width cycles.
//
// state | meaning
// IDLE  | waiting for valid_in, product holds the last result
// CALC  | one shift-add iteration per cycle, width iterations total
module mul_add_reconstruct #(
  parameter int width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [width-1:0]     multiplicand,
  input  logic [width-1:0]     multiplier,
  input  logic [width-1:0]     addend,
  input  logic                 valid_in,
  output logic                 busy,
  output logic                 valid_out,
  output logic [2*width-1:0]   product
);

  localparam int CW = (width > 1) ? $clog2(width) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(width - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t               state_q, state_d;
  logic [2*width-1:0]   a_q, a_d;
  logic [width-1:0]     b_q, b_d;
  logic [2*width-1:0]   acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 valid_out_q, valid_out_d;
  logic [2*width-1:0]   product_q, product_d;
  logic [2*width-1:0]   acc_sum;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    count_d     = count_q;
    busy_d      = busy_q;
    valid_out_d = 1'b0;
    product_d   = product_q;
    acc_sum     = acc_q;

    if (state_q == IDLE) begin
      if (valid_in) begin
        a_d     = {{width{1'b0}}, multiplicand};
        b_d     = multiplier;
        acc_d   = {{width{1'b0}}, addend};
        count_d = '0;
        busy_d  = 1'b1;
        state_d = CALC;
      end
    end else begin
      // Max result is 2^2w - 2^w, so the 2w-bit sum never carries out.
      acc_sum = b_q[0] ? (acc_q + a_q) : acc_q;
      acc_d   = acc_sum;
      a_d     = a_q << 1;
      b_d     = b_q >> 1;
      count_d = count_q + CW'(1);
      if (count_q == COUNT_LAST) begin
        product_d   = acc_sum;
        valid_out_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      valid_out_q <= 1'b0;
      product_q   <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      valid_out_q <= valid_out_d;
      product_q   <= product_d;
    end
  end

  assign busy      = busy_q;
  assign valid_out = valid_out_q;
  assign product   = product_q;

endmodule
